// File: rtl/fft_radix2_iter.sv
// Purpose : iterative in-place radix-2 DIT FFT, N = 2**LOG2N points, one shared butterfly.
// Latency : done rises LOG2N*N/2 + 2 edges after the accepted-start edge.
// Backpres: none; start is taken only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clock, reset   system clock; synchronous active-high reset
//   start, inverse request and direction (inverse = conjugate twiddles, no 1/N)
//   A_In           N packed complex samples {re[WIDTH-1:H], im[H-1:0]}, captured on start
//   A_Out          registered natural-order results, held until the next COPY
//   busy, done     busy in RUN/COPY, done in DONE
// Build option: define FFT_STAGE_SCALE_EN to halve every butterfly output
// (total gain 1/N); otherwise results grow by N and saturate.
module fft_radix2_iter #(
    parameter int WIDTH = 32,
    parameter int LOG2N = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               inverse,
    input  logic [2**LOG2N-1:0][WIDTH-1:0]     A_In,
    output logic [2**LOG2N-1:0][WIDTH-1:0]     A_Out,
    output logic                               busy,
    output logic                               done
);

    localparam int N  = 2**LOG2N;
    localparam int H  = WIDTH / 2;
    localparam int JW = LOG2N - 1;
    localparam int PW = H + 17;

    if (LOG2N < 2 || LOG2N > 4) begin : g_bad_log2n
        $error("fft_radix2_iter: LOG2N must be 2..4");
    end

    localparam logic signed [H+1:0] MAXV = (H+2)'((1 << (H-1)) - 1);
    localparam logic signed [H+1:0] MINV = ~MAXV;
    localparam logic [JW-1:0]       JMAX = JW'(N/2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_COPY, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               s_q, s_d;
    logic [JW-1:0]            j_q, j_d;
    logic                     fin_q, fin_d;
    logic                     inv_q, inv_d;
    logic [N-1:0][WIDTH-1:0]  buf_q, buf_d;
    logic [N-1:0][WIDTH-1:0]  a_out_q, a_out_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        for (int b = 0; b < LOG2N; b++) bitrev[b] = x[LOG2N-1-b];
    endfunction

    // W16^t = cos - j*sin, Q1.14
    function automatic logic signed [15:0] tw_cos(input logic [2:0] t);
        case (t)
            3'd0:    tw_cos = 16'sd16384;
            3'd1:    tw_cos = 16'sd15137;
            3'd2:    tw_cos = 16'sd11585;
            3'd3:    tw_cos = 16'sd6270;
            3'd4:    tw_cos = 16'sd0;
            3'd5:    tw_cos = -16'sd6270;
            3'd6:    tw_cos = -16'sd11585;
            default: tw_cos = -16'sd15137;
        endcase
    endfunction

    function automatic logic signed [15:0] tw_sin(input logic [2:0] t);
        case (t)
            3'd0:    tw_sin = 16'sd0;
            3'd1:    tw_sin = 16'sd6270;
            3'd2:    tw_sin = 16'sd11585;
            3'd3:    tw_sin = 16'sd15137;
            3'd4:    tw_sin = 16'sd16384;
            3'd5:    tw_sin = 16'sd15137;
            3'd6:    tw_sin = 16'sd11585;
            default: tw_sin = 16'sd6270;
        endcase
    endfunction

    function automatic logic [H-1:0] sat(input logic signed [H+1:0] v);
        if (v > MAXV)      sat = {1'b0, {(H-1){1'b1}}};
        else if (v < MINV) sat = {1'b1, {(H-1){1'b0}}};
        else               sat = v[H-1:0];
    endfunction

    // ---------------- butterfly addressing ----------------
    int                h_i, k_i, top_i, bot_i, t_i;
    logic [LOG2N-1:0]  top_a, bot_a;
    logic [2:0]        t_a;

    always_comb begin
        h_i   = 1 << s_q;
        k_i   = int'(j_q) & (h_i - 1);
        top_i = (int'(j_q) >> s_q) * 2 * h_i + k_i;
        bot_i = top_i + h_i;
        t_i   = k_i << (3 - int'(s_q));
        top_a = LOG2N'(top_i);
        bot_a = LOG2N'(bot_i);
        t_a   = 3'(t_i);
    end

    // ---------------- shared butterfly datapath ----------------
    logic [WIDTH-1:0]        a_w, b_w;
    logic signed [H-1:0]     a_re, a_im, b_re, b_im;
    logic signed [15:0]      w_re, w_im;
    logic signed [PW-1:0]    p_re_f, p_im_f;
    logic signed [H:0]       p_re, p_im;
    logic signed [H+1:0]     tr_sum, ti_sum, br_sum, bi_sum;
    logic signed [H+1:0]     tr_sc, ti_sc, br_sc, bi_sc;
    logic [WIDTH-1:0]        top_new, bot_new;

    assign a_w  = buf_q[top_a];
    assign b_w  = buf_q[bot_a];
    assign a_re = a_w[WIDTH-1:H];
    assign a_im = a_w[H-1:0];
    assign b_re = b_w[WIDTH-1:H];
    assign b_im = b_w[H-1:0];

    // Inverse mode conjugates the twiddle: the sin term flips sign.
    assign w_re = tw_cos(t_a);
    assign w_im = inv_q ? tw_sin(t_a) : -tw_sin(t_a);

    assign p_re_f = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    assign p_im_f = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);

    // |W| <= 1, so the rescaled product always fits in H+1 bits.
    assign p_re = (H+1)'(p_re_f >>> 14);
    assign p_im = (H+1)'(p_im_f >>> 14);

    assign tr_sum = (H+2)'(a_re) + (H+2)'(p_re);
    assign ti_sum = (H+2)'(a_im) + (H+2)'(p_im);
    assign br_sum = (H+2)'(a_re) - (H+2)'(p_re);
    assign bi_sum = (H+2)'(a_im) - (H+2)'(p_im);

`ifdef FFT_STAGE_SCALE_EN
    assign tr_sc = tr_sum >>> 1;
    assign ti_sc = ti_sum >>> 1;
    assign br_sc = br_sum >>> 1;
    assign bi_sc = bi_sum >>> 1;
`else
    assign tr_sc = tr_sum;
    assign ti_sc = ti_sum;
    assign br_sc = br_sum;
    assign bi_sc = bi_sum;
`endif

    assign top_new = {sat(tr_sc), sat(ti_sc)};
    assign bot_new = {sat(br_sc), sat(bi_sc)};

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        fin_d   = fin_q;
        inv_d   = inv_q;
        buf_d   = buf_q;
        a_out_d = a_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) buf_d[bitrev(LOG2N'(i))] = A_In[i];
                    inv_d   = inverse;
                    s_d     = 2'd0;
                    j_d     = '0;
                    fin_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // fin_q marks the drain cycle after the final butterfly.
                if (fin_q) begin
                    state_d = S_COPY;
                end else begin
                    buf_d[top_a] = top_new;
                    buf_d[bot_a] = bot_new;
                    if (j_q == JMAX) begin
                        j_d = '0;
                        if (s_q == 2'(LOG2N - 1)) fin_d = 1'b1;
                        else                      s_d   = s_q + 2'd1;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            S_COPY: begin
                a_out_d = buf_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_COPY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            s_q     <= 2'd0;
            j_q     <= '0;
            fin_q   <= 1'b0;
            inv_q   <= 1'b0;
            buf_q   <= '0;
            a_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            fin_q   <= fin_d;
            inv_q   <= inv_d;
            buf_q   <= buf_d;
            a_out_q <= a_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A_Out = a_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
